// File: rtl/seq_muldiv_unit_if.sv
// Request and write-back bundle between the register file and seq_muldiv_unit.
// The master issues operations; the slave (the unit) returns results.
interface seq_muldiv_unit_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 3
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [AW-1:0]    dest;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] wb_data;
    logic [AW-1:0]    wb_addr;
    logic             wb_en;
    logic [WIDTH-1:0] hi;
    logic             div_by_zero;

    modport master (
        output start, op, a, b, dest,
        input  busy, done, wb_data, wb_addr, wb_en, hi, div_by_zero
    );

    modport slave (
        input  start, op, a, b, dest,
        output busy, done, wb_data, wb_addr, wb_en, hi, div_by_zero
    );
endinterface

// File: rtl/seq_muldiv_unit.sv
// Bit-serial multiply/divide unit that writes results back through its own write port.
// Define MULDIV_SIGNED_EN to enable two's-complement signed mode selected by op[1].
module seq_muldiv_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 3
) (
    input logic              clk,
    input logic              rst,
    seq_muldiv_unit_if.slave bus
);
    localparam int unsigned   CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StWb} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;  // multiplicand for MUL, divisor for DIV
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
    logic [AW-1:0]    dest_q, dest_d;
    logic             busy_q, busy_d, done_q, done_d, wb_en_q, wb_en_d, dbz_q, dbz_d;
    logic [WIDTH-1:0] wb_data_q, wb_data_d, hi_q, hi_d;
    logic [AW-1:0]    wb_addr_q, wb_addr_d;

    logic [WIDTH:0]   mul_sum, div_trial;
    logic [WIDTH-1:0] step_hi, step_lo, res_hi, res_lo, in_a, in_b;

`ifdef MULDIV_SIGNED_EN
    logic               neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d, sign_a, sign_b;
    logic [2*WIDTH-1:0] prod_neg;

    always_comb begin
        sign_a = bus.op[1] & bus.a[WIDTH-1];
        sign_b = bus.op[1] & bus.b[WIDTH-1];
        in_a   = sign_a ? -bus.a : bus.a;
        in_b   = sign_b ? -bus.b : bus.b;
    end
`else
    logic unused_op;
    assign unused_op = bus.op[1];
    assign in_a      = bus.a;
    assign in_b      = bus.b;
`endif

    // One datapath step: MUL shifts the product right, DIV shifts the remainder left.
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        div_trial = {acc_hi_q, acc_lo_q[WIDTH-1]} - {1'b0, opnd_q};
        if (!is_div_q) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end else if (!div_trial[WIDTH]) begin
            step_hi = div_trial[WIDTH-1:0];
            step_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
        end else begin
            step_hi = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
            step_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        res_hi = step_hi;
        res_lo = step_lo;
`ifdef MULDIV_SIGNED_EN
        prod_neg = -{step_hi, step_lo};
        if (is_div_q) begin
            if (neg_lo_q) res_lo = -step_lo;
            if (neg_hi_q) res_hi = -step_hi;
        end else if (neg_lo_q) begin
            {res_hi, res_lo} = prod_neg;
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        opnd_d    = opnd_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        dest_d    = dest_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        wb_en_d   = 1'b0;
        dbz_d     = dbz_q;
        wb_data_d = wb_data_q;
        hi_d      = hi_q;
        wb_addr_d = wb_addr_q;
`ifdef MULDIV_SIGNED_EN
        neg_lo_d  = neg_lo_q;
        neg_hi_d  = neg_hi_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    is_div_d = bus.op[0];
                    dest_d   = bus.dest;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    opnd_d   = bus.op[0] ? in_b : in_a;
                    acc_lo_d = bus.op[0] ? in_a : in_b;
                    acc_hi_d = '0;
`ifdef MULDIV_SIGNED_EN
                    neg_lo_d = sign_a ^ sign_b;
                    neg_hi_d = sign_a;
`endif
                    if (bus.op[0] && bus.b == '0) begin
                        state_d   = StWb;
                        done_d    = 1'b1;
                        wb_en_d   = (bus.dest != '0);
                        wb_addr_d = bus.dest;
                        wb_data_d = '1;
                        hi_d      = bus.a;
                        dbz_d     = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d   = StWb;
                    done_d    = 1'b1;
                    wb_en_d   = (dest_q != '0);
                    wb_addr_d = dest_q;
                    wb_data_d = res_lo;
                    hi_d      = res_hi;
                    dbz_d     = 1'b0;
                end
            end
            StWb: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            opnd_q    <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            dest_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wb_en_q   <= 1'b0;
            dbz_q     <= 1'b0;
            wb_data_q <= '0;
            hi_q      <= '0;
            wb_addr_q <= '0;
`ifdef MULDIV_SIGNED_EN
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            opnd_q    <= opnd_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            dest_q    <= dest_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wb_en_q   <= wb_en_d;
            dbz_q     <= dbz_d;
            wb_data_q <= wb_data_d;
            hi_q      <= hi_d;
            wb_addr_q <= wb_addr_d;
`ifdef MULDIV_SIGNED_EN
            neg_lo_q  <= neg_lo_d;
            neg_hi_q  <= neg_hi_d;
`endif
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.wb_en       = wb_en_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.wb_addr     = wb_addr_q;
    assign bus.hi          = hi_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_muldiv_unit.sv
// Scoreboard bench for seq_muldiv_unit: expectations queued at issue, checked on each done.
module tb_seq_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   passed = 0;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] hi;
        logic [2:0] addr;
        logic       en;
        logic       dbz;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_exp;

    seq_muldiv_unit_if #(.WIDTH(8), .AW(3)) bus ();

    seq_muldiv_unit #(.WIDTH(8), .AW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench stopped by watchdog");
    end

    function automatic exp_t mk(input logic [7:0] d, input logic [7:0] h, input logic [2:0] ad,
                                input logic en, input logic dbz);
        exp_t e;
        e.data = d; e.hi = h; e.addr = ad; e.en = en; e.dbz = dbz;
        return e;
    endfunction

    // Reference model using the simulator's own arithmetic.
    function automatic exp_t model(input logic [1:0] op, input logic [7:0] a,
                                   input logic [7:0] b, input logic [2:0] dest);
        exp_t        e;
        logic [15:0] p;
        int          ia, ib, r;
        e = mk(8'h00, 8'h00, dest, dest != 3'd0, 1'b0);
        ia = int'(a);
        ib = int'(b);
`ifdef MULDIV_SIGNED_EN
        if (op[1]) begin
            ia = int'($signed(a));
            ib = int'($signed(b));
        end
`endif
        if (!op[0]) begin
            r = ia * ib;
            p = r[15:0];
            e.data = p[7:0];
            e.hi = p[15:8];
        end else if (b == 8'h00) begin
            e.data = 8'hFF;
            e.hi = a;
            e.dbz = 1'b1;
        end else begin
            r = ia / ib;
            e.data = r[7:0];
            r = ia % ib;
            e.hi = r[7:0];
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst && bus.done) begin
            checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL wb_result unexpected done: got %h/%h addr %0d en %b dbz %b, none queued",
                         bus.wb_data, bus.hi, bus.wb_addr, bus.wb_en, bus.div_by_zero);
            end else begin
                mon_exp = sb_q.pop_front();
                if ({bus.wb_data, bus.hi, bus.wb_addr, bus.wb_en, bus.div_by_zero} !== mon_exp)
                    $display("FAIL wb_result got data %h hi %h addr %0d en %b dbz %b, want %h %h %0d %b %b",
                             bus.wb_data, bus.hi, bus.wb_addr, bus.wb_en, bus.div_by_zero,
                             mon_exp.data, mon_exp.hi, mon_exp.addr, mon_exp.en, mon_exp.dbz);
                else
                    passed++;
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] dest, input bit push, input exp_t e);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        bus.dest = dest;
        if (push) sb_q.push_back(e);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a = 8'($urandom);
        bus.b = 8'($urandom);
        bus.op = 2'($urandom);
        bus.dest = 3'($urandom);
    endtask

    task automatic wait_done(input int limit, output int n, output bit to);
        n = 0;
        to = 1'b1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            n++;
            if (bus.done) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.wb_en, bus.div_by_zero, bus.wb_data, bus.wb_addr, bus.hi}
            !== '0)
            $display("FAIL reset_outputs got busy %b done %b en %b dbz %b data %h addr %0d hi %h, want 0",
                     bus.busy, bus.done, bus.wb_en, bus.div_by_zero, bus.wb_data, bus.wb_addr, bus.hi);
        else passed++;
        rst = 1'b1;
    endtask

    task automatic test_mul();
        int n;
        bit to;
        issue(2'b00, 8'd13, 8'd11, 3'd3, 1'b1, mk(8'h8F, 8'h00, 3'd3, 1'b1, 1'b0));
        wait_done(20, n, to);
        checks++;
        if (to || n != 9) $display("FAIL mul_latency got %0d timeout %b, want 9", n, to);
        else passed++;
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.wb_en !== 1'b0)
            $display("FAIL mul_done_pulse got done %b en %b, want 0 0", bus.done, bus.wb_en);
        else passed++;
    endtask

    task automatic test_mul_busy();
        int cnt = 0;
        issue(2'b00, 8'd200, 8'd200, 3'd5, 1'b1, mk(8'h40, 8'h9C, 3'd5, 1'b1, 1'b0));
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.busy) cnt++;
            else if (cnt > 0) break;
        end
        checks++;
        if (cnt != 9) $display("FAIL mul_busy_cycles got %0d, want 9", cnt);
        else passed++;
    endtask

    task automatic test_div();
        int n;
        bit to;
        issue(2'b01, 8'd100, 8'd7, 3'd2, 1'b1, mk(8'h0E, 8'h02, 3'd2, 1'b1, 1'b0));
        wait_done(20, n, to);
        checks++;
        if (to || n != 9) $display("FAIL div_latency got %0d timeout %b, want 9", n, to);
        else passed++;
    endtask

    task automatic test_div_zero();
        int n;
        bit to;
        issue(2'b01, 8'd5, 8'd0, 3'd4, 1'b1, mk(8'hFF, 8'h05, 3'd4, 1'b1, 1'b1));
        wait_done(20, n, to);
        checks++;
        if (to || n != 1) $display("FAIL div0_latency got %0d timeout %b, want 1", n, to);
        else passed++;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.div_by_zero !== 1'b1)
            $display("FAIL div0_hold got busy %b dbz %b, want 0 1", bus.busy, bus.div_by_zero);
        else passed++;
    endtask

    task automatic test_dest_zero();
        int n;
        int extra = 0;
        bit to;
        issue(2'b00, 8'd9, 8'd9, 3'd0, 1'b1, mk(8'h51, 8'h00, 3'd0, 1'b0, 1'b0));
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op = 2'b00;
        bus.a = 8'd3;
        bus.b = 8'd3;
        bus.dest = 3'd1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(20, n, to);
        checks++;
        if (to || n != 6 || bus.wb_en !== 1'b0)
            $display("FAIL dest0_done got n %0d timeout %b en %b, want 6 0 0", n, to, bus.wb_en);
        else passed++;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done || bus.wb_en) extra++;
        end
        checks++;
        if (extra != 0) $display("FAIL busy_start_ignored got %0d extra strobes, want 0", extra);
        else passed++;
    endtask

    task automatic test_reset_mid_op();
        int extra = 0;
        issue(2'b00, 8'd7, 8'd7, 3'd6, 1'b0, mk(8'h00, 8'h00, 3'd0, 1'b0, 1'b0));
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.wb_en, bus.div_by_zero, bus.wb_data, bus.wb_addr, bus.hi}
            !== '0)
            $display("FAIL midop_reset got busy %b data %h addr %0d hi %h, want all 0",
                     bus.busy, bus.wb_data, bus.wb_addr, bus.hi);
        else passed++;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done || bus.wb_en || bus.busy) extra++;
        end
        checks++;
        if (extra != 0) $display("FAIL midop_dropped got %0d active cycles, want 0", extra);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int n;
        bit to;
        issue(2'b00, 8'd3, 8'd5, 3'd1, 1'b1, mk(8'h0F, 8'h00, 3'd1, 1'b1, 1'b0));
        wait_done(20, n, to);
        // Start held from the done cycle: the WB-cycle edge must ignore it.
        bus.start = 1'b1;
        bus.op = 2'b01;
        bus.a = 8'd200;
        bus.b = 8'd9;
        bus.dest = 3'd7;
        sb_q.push_back(mk(8'h16, 8'h02, 3'd7, 1'b1, 1'b0));
        @(negedge clk);
        checks++;
        if (to || bus.busy !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL wb_start_ignored got busy %b done %b timeout %b, want 0 0 0",
                     bus.busy, bus.done, to);
        else passed++;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) $display("FAIL accept_after_done got busy %b, want 1", bus.busy);
        else passed++;
        bus.start = 1'b0;
        wait_done(20, n, to);
        checks++;
        if (to || n != 8) $display("FAIL b2b_latency got %0d timeout %b, want 8", n, to);
        else passed++;
    endtask

    task automatic test_random();
        int         n;
        bit         to;
        logic [1:0] op;
        logic [7:0] a, b;
        logic [2:0] d;
        exp_t       e;
        for (int i = 0; i < 12; i++) begin
            op = {1'b0, 1'($urandom_range(0, 1))};
            a = 8'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            d = 3'($urandom);
            e = model(op, a, b, d);
            issue(op, a, b, d, 1'b1, e);
            wait_done(20, n, to);
            checks++;
            if (to || n != (e.dbz ? 1 : 9))
                $display("FAIL rand_latency[%0d] got %0d timeout %b, want %0d", i, n, to,
                         e.dbz ? 1 : 9);
            else passed++;
        end
    endtask

`ifdef MULDIV_SIGNED_EN
    task automatic test_signed();
        int n;
        bit to;
        issue(2'b10, 8'hFA, 8'h07, 3'd1, 1'b1, mk(8'hD6, 8'hFF, 3'd1, 1'b1, 1'b0));
        wait_done(20, n, to);
        issue(2'b11, 8'hF9, 8'h02, 3'd2, 1'b1, mk(8'hFD, 8'hFF, 3'd2, 1'b1, 1'b0));
        wait_done(20, n, to);
        checks++;
        if (to || n != 9) $display("FAIL signed_latency got %0d timeout %b, want 9", n, to);
        else passed++;
    endtask
`endif

    initial begin
        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.a = 8'h00;
        bus.b = 8'h00;
        bus.dest = 3'd0;
        test_reset();
        test_mul();
        test_mul_busy();
        test_div();
        test_div_zero();
        test_dest_zero();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
`ifdef MULDIV_SIGNED_EN
        test_signed();
`endif
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) $display("FAIL scoreboard_drained got %0d left, want 0", sb_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
